// File: rtl/i2c_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_ram_arbiter
// Description : Turns the level-style controls of the I2C memory state
//               machine into single RAM accesses through an internal address
//               pointer. Round-robin shares the single-port RAM with a local
//               host request/grant port.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i2c_addr_load,
    input  logic [DATA_W-1:0] i2c_addr_byte,
    input  logic              i2c_wr_req,
    input  logic [DATA_W-1:0] i2c_wdata,
    input  logic              i2c_rd_req,
    input  logic              i2c_incr,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_rdata_valid,
    output logic              i2c_overrun,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rdata_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I2C_WR  = 3'd1,
        I2C_RD  = 3'd2,
        HOST_WR = 3'd3,
        HOST_RD = 3'd4,
        RD_WAIT = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;

    logic              prev_load;
    logic              prev_wr;
    logic              prev_rd;
    logic              prev_incr;
    logic              load_edge;
    logic              wr_edge;
    logic              rd_edge;
    logic              incr_edge;

    logic [ADDR_W-1:0] ptr;
    logic              wr_pend;
    logic              rd_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_clr;
    logic              rd_clr;

    logic              last_i2c;
    logic              rd_for_i2c;

    assign load_edge = i2c_addr_load & ~prev_load;
    assign wr_edge   = i2c_wr_req    & ~prev_wr;
    assign rd_edge   = i2c_rd_req    & ~prev_rd;
    assign incr_edge = i2c_incr      & ~prev_incr;

    // A pending request is retired in the cycle its access is on the RAM port
    assign wr_clr = (state == I2C_WR);
    assign rd_clr = (state == I2C_RD);

    // Previous levels of the I2C controls, so each rising edge counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_load <= 1'b0;
            prev_wr   <= 1'b0;
            prev_rd   <= 1'b0;
            prev_incr <= 1'b0;
        end else begin
            prev_load <= i2c_addr_load;
            prev_wr   <= i2c_wr_req;
            prev_rd   <= i2c_rd_req;
            prev_incr <= i2c_incr;
        end
    end

    // Address pointer: load has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load_edge) begin
            ptr <= i2c_addr_byte[ADDR_W-1:0];
        end else if (incr_edge) begin
            ptr <= ptr + PTR_STEP;
        end
    end

    // Pending I2C requests with their latched address/data and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_addr     <= '0;
            i2c_overrun <= 1'b0;
        end else begin
            if (wr_edge) begin
                wr_pend <= 1'b1;
                wr_addr <= ptr;
                wr_data <= i2c_wdata;
                if (wr_pend && !wr_clr) begin
                    i2c_overrun <= 1'b1;
                end
            end else if (wr_clr) begin
                wr_pend <= 1'b0;
            end
            if (rd_edge) begin
                rd_pend <= 1'b1;
                rd_addr <= ptr;
                if (rd_pend && !rd_clr) begin
                    i2c_overrun <= 1'b1;
                end
            end else if (rd_clr) begin
                rd_pend <= 1'b0;
            end
        end
    end

    // Next-state decision: round-robin between I2C and host on a tie
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((wr_pend || rd_pend) && !(host_req && last_i2c)) begin
                    state_nxt = wr_pend ? I2C_WR : I2C_RD;
                end else if (host_req) begin
                    state_nxt = host_we ? HOST_WR : HOST_RD;
                end
            end
            I2C_WR, HOST_WR: state_nxt = IDLE;
            I2C_RD, HOST_RD: state_nxt = RD_WAIT;
            RD_WAIT:         state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    // State register plus fairness bit and read-owner tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_i2c   <= 1'b0;
            rd_for_i2c <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                case (state_nxt)
                    I2C_WR, I2C_RD:   last_i2c <= 1'b1;
                    HOST_WR, HOST_RD: last_i2c <= 1'b0;
                    default:          last_i2c <= last_i2c;
                endcase
            end
            if (state == I2C_RD) begin
                rd_for_i2c <= 1'b1;
            end else if (state == HOST_RD) begin
                rd_for_i2c <= 1'b0;
            end
        end
    end

    // Registered RAM port and host grant, loaded for the upcoming access state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            host_gnt  <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
            host_gnt <= 1'b0;
            case (state_nxt)
                I2C_WR: begin
                    ram_we    <= 1'b1;
                    ram_addr  <= wr_addr;
                    ram_wdata <= wr_data;
                end
                I2C_RD: begin
                    ram_addr <= rd_addr;
                end
                HOST_WR: begin
                    ram_we    <= 1'b1;
                    ram_addr  <= host_addr;
                    ram_wdata <= host_wdata;
                    host_gnt  <= 1'b1;
                end
                HOST_RD: begin
                    ram_addr <= host_addr;
                    host_gnt <= 1'b1;
                end
                default: begin
                    ram_addr  <= ram_addr;
                end
            endcase
        end
    end

    // Capture RAM read data in RD_WAIT and pulse the owner's valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c_rdata        <= '0;
            i2c_rdata_valid  <= 1'b0;
            host_rdata       <= '0;
            host_rdata_valid <= 1'b0;
        end else begin
            i2c_rdata_valid  <= 1'b0;
            host_rdata_valid <= 1'b0;
            if (state == RD_WAIT) begin
                if (rd_for_i2c) begin
                    i2c_rdata       <= ram_rdata;
                    i2c_rdata_valid <= 1'b1;
                end else begin
                    host_rdata       <= ram_rdata;
                    host_rdata_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_ram_arbiter
// Description : Self-checking bench for i2c_ram_arbiter. A timeline model of
//               the arbiter predicts every output each cycle; directed
//               scenarios are followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i2c_addr_load, i2c_wr_req, i2c_rd_req, i2c_incr;
    logic [DW-1:0] i2c_addr_byte, i2c_wdata;
    logic [DW-1:0] i2c_rdata;
    logic          i2c_rdata_valid, i2c_overrun;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rdata_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] ram_mem [0:255] = '{default: 8'h00};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    i2c_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i2c_addr_load(i2c_addr_load), .i2c_addr_byte(i2c_addr_byte),
        .i2c_wr_req(i2c_wr_req), .i2c_wdata(i2c_wdata),
        .i2c_rd_req(i2c_rd_req), .i2c_incr(i2c_incr),
        .i2c_rdata(i2c_rdata), .i2c_rdata_valid(i2c_rdata_valid),
        .i2c_overrun(i2c_overrun),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- observation records (from DUT) ----------------
    logic          gnt_last = 1'b0;
    int            we_count = 0;
    logic [7:0]    last_we_addr = '0, last_we_data = '0;
    logic [7:0]    i2c_q[$];
    logic [7:0]    host_q[$];
    int            i2c_vcyc[$];
    int            last_gnt_cyc = 0, last_hval_cyc = 0;

    // ---------------- timeline model ----------------
    logic [7:0] m_mem [0:255];
    logic [7:0] m_ptr, m_wr_addr, m_wr_data, m_rd_addr;
    logic       m_prev_ld, m_prev_wr, m_prev_rd, m_prev_inc;
    logic       m_wr_pend, m_rd_pend, m_last_i2c, m_ovr;
    int         m_free_at, acc_at, val_at, wr_clr_at, rd_clr_at;
    logic       acc_we, acc_host, val_i2c;
    logic [7:0] acc_addr, acc_wdata, val_data;
    logic [7:0] e_ram_addr, e_ram_wdata, e_i2c_rdata, e_host_rdata;

    task automatic model_reset();
        m_ptr = '0; m_wr_addr = '0; m_wr_data = '0; m_rd_addr = '0;
        m_prev_ld = 0; m_prev_wr = 0; m_prev_rd = 0; m_prev_inc = 0;
        m_wr_pend = 0; m_rd_pend = 0; m_last_i2c = 0; m_ovr = 0;
        m_free_at = 0; acc_at = -1; val_at = -1; wr_clr_at = -1; rd_clr_at = -1;
        acc_we = 0; acc_host = 0; val_i2c = 0;
        acc_addr = '0; acc_wdata = '0; val_data = '0;
        e_ram_addr = '0; e_ram_wdata = '0; e_i2c_rdata = '0; e_host_rdata = '0;
    endtask

    // Each negedge: compare DUT against the model, then advance the model
    initial begin
        logic e_we, e_gnt, e_iv, e_hv, ld_e, wr_e, rd_e, inc_e, go_i2c, go_host;
        for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            e_we = 0; e_gnt = 0; e_iv = 0; e_hv = 0;
            if (!rst_n) begin
                model_reset();
            end else begin
                if (acc_at == cyc) begin
                    e_ram_addr = acc_addr;
                    e_we = acc_we;
                    if (acc_we) e_ram_wdata = acc_wdata;
                    e_gnt = acc_host;
                end
                if (val_at == cyc) begin
                    if (val_i2c) begin e_i2c_rdata = val_data; e_iv = 1; end
                    else begin e_host_rdata = val_data; e_hv = 1; end
                end
            end
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(e_ram_wdata));
            chk("host_gnt", 32'(host_gnt), 32'(e_gnt));
            chk("i2c_rdata_valid", 32'(i2c_rdata_valid), 32'(e_iv));
            chk("i2c_rdata", 32'(i2c_rdata), 32'(e_i2c_rdata));
            chk("host_rdata_valid", 32'(host_rdata_valid), 32'(e_hv));
            chk("host_rdata", 32'(host_rdata), 32'(e_host_rdata));
            chk("i2c_overrun", 32'(i2c_overrun), 32'(m_ovr));

            // observation records for the directed literal checks
            gnt_last = host_gnt;
            if (host_gnt) last_gnt_cyc = cyc;
            if (ram_we) begin we_count++; last_we_addr = ram_addr; last_we_data = ram_wdata; end
            if (i2c_rdata_valid) begin i2c_q.push_back(i2c_rdata); i2c_vcyc.push_back(cyc); end
            if (host_rdata_valid) begin host_q.push_back(host_rdata); last_hval_cyc = cyc; end

            if (rst_n) begin
                // arbitration when the RAM is free this cycle
                if (cyc >= m_free_at) begin
                    go_i2c  = (m_wr_pend || m_rd_pend) && !(host_req && m_last_i2c);
                    go_host = host_req && !go_i2c;
                    if (go_i2c) begin
                        m_last_i2c = 1;
                        acc_at = cyc + 1; acc_host = 0;
                        if (m_wr_pend) begin
                            acc_we = 1; acc_addr = m_wr_addr; acc_wdata = m_wr_data;
                            m_mem[m_wr_addr] = m_wr_data;
                            wr_clr_at = cyc + 1; m_free_at = cyc + 2;
                        end else begin
                            acc_we = 0; acc_addr = m_rd_addr;
                            val_at = cyc + 3; val_i2c = 1; val_data = m_mem[m_rd_addr];
                            rd_clr_at = cyc + 1; m_free_at = cyc + 3;
                        end
                    end else if (go_host) begin
                        m_last_i2c = 0;
                        acc_at = cyc + 1; acc_host = 1; acc_addr = host_addr;
                        if (host_we) begin
                            acc_we = 1; acc_wdata = host_wdata;
                            m_mem[host_addr] = host_wdata;
                            m_free_at = cyc + 2;
                        end else begin
                            acc_we = 0;
                            val_at = cyc + 3; val_i2c = 0; val_data = m_mem[host_addr];
                            m_free_at = cyc + 3;
                        end
                    end
                end
                // I2C edges seen this cycle
                ld_e  = i2c_addr_load & ~m_prev_ld;
                wr_e  = i2c_wr_req & ~m_prev_wr;
                rd_e  = i2c_rd_req & ~m_prev_rd;
                inc_e = i2c_incr & ~m_prev_inc;
                if (wr_e) begin
                    if (m_wr_pend && wr_clr_at != cyc) m_ovr = 1;
                    m_wr_pend = 1; m_wr_addr = m_ptr; m_wr_data = i2c_wdata;
                end else if (wr_clr_at == cyc) m_wr_pend = 0;
                if (rd_e) begin
                    if (m_rd_pend && rd_clr_at != cyc) m_ovr = 1;
                    m_rd_pend = 1; m_rd_addr = m_ptr;
                end else if (rd_clr_at == cyc) m_rd_pend = 0;
                if (ld_e) m_ptr = i2c_addr_byte;
                else if (inc_e) m_ptr = m_ptr + 8'd1;
                m_prev_ld = i2c_addr_load; m_prev_wr = i2c_wr_req;
                m_prev_rd = i2c_rd_req; m_prev_inc = i2c_incr;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d);
        int n;
        host_req = 1; host_we = we; host_addr = a; host_wdata = d;
        n = 0;
        do begin tick(1); n++; end while (!gnt_last && n < 20);
        chk("host_gnt_seen", 32'(gnt_last), 32'd1);
        host_req = 0;
        tick(4);
    endtask

    initial begin
        int n, wc0, hq0;
        rst_n = 0;
        i2c_addr_load = 0; i2c_wr_req = 0; i2c_rd_req = 0; i2c_incr = 0;
        i2c_addr_byte = '0; i2c_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        tick(3);
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'd0);
        rst_n = 1;
        tick(2);

        // preload through the host port
        host_op(1, 8'hFF, 8'h11);
        host_op(1, 8'h00, 8'h22);
        host_op(1, 8'h10, 8'h5A);

        // pointer load then a held write request
        wc0 = we_count;
        i2c_addr_byte = 8'h3C; i2c_addr_load = 1; tick(1);
        i2c_addr_load = 0; i2c_wdata = 8'hA5; i2c_wr_req = 1; tick(50);
        i2c_wr_req = 0; tick(2);
        chk("ptr_write_count", 32'(we_count - wc0), 32'd1);
        chk("ptr_write_addr", 32'(last_we_addr), 32'h3C);
        chk("ptr_write_data", 32'(last_we_data), 32'hA5);

        // reads across the pointer wrap
        i2c_q.delete();
        i2c_addr_byte = 8'hFF; i2c_addr_load = 1; tick(1);
        i2c_addr_load = 0; i2c_rd_req = 1; tick(1);
        i2c_rd_req = 0; tick(5);
        i2c_incr = 1; tick(1);
        i2c_incr = 0; tick(1);
        i2c_rd_req = 1; tick(1);
        i2c_rd_req = 0; tick(6);
        chk("wrap_read_count", 32'(i2c_q.size()), 32'd2);
        if (i2c_q.size() == 2) begin
            chk("wrap_read0", 32'(i2c_q[0]), 32'h11);
            chk("wrap_read1", 32'(i2c_q[1]), 32'h22);
        end

        // host read
        host_q.delete();
        host_op(0, 8'h10, 8'h00);
        chk("host_read_count", 32'(host_q.size()), 32'd1);
        if (host_q.size() == 1) chk("host_read_data", 32'(host_q[0]), 32'h5A);
        chk("host_gnt_to_valid", 32'(last_hval_cyc - last_gnt_cyc), 32'd2);

        // contention: I2C read and host write tie, then a repeat tie
        i2c_vcyc.delete();
        i2c_rd_req = 1; tick(1);
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'h77; i2c_rd_req = 0; tick(1);
        i2c_rd_req = 1; tick(1);
        i2c_rd_req = 0;
        n = 0;
        while (!gnt_last && n < 20) begin tick(1); n++; end
        chk("tie_host_gnt_seen", 32'(gnt_last), 32'd1);
        host_req = 0; tick(8);
        chk("tie_i2c_reads", 32'(i2c_vcyc.size()), 32'd2);
        if (i2c_vcyc.size() == 2) begin
            chk("tie_i2c_first", 32'(last_gnt_cyc - i2c_vcyc[0]), 32'd1);
            chk("tie_host_second", 32'(i2c_vcyc[1] - last_gnt_cyc), 32'd4);
        end

        // simultaneous load+incr, then simultaneous write+read
        i2c_addr_byte = 8'h40; i2c_addr_load = 1; i2c_incr = 1; tick(1);
        i2c_addr_load = 0; i2c_incr = 0; i2c_wdata = 8'h99; i2c_wr_req = 1; i2c_rd_req = 1; tick(1);
        i2c_wr_req = 0; i2c_rd_req = 0; tick(8);
        chk("sim_write_addr", 32'(last_we_addr), 32'h40);
        chk("sim_write_data", 32'(last_we_data), 32'h99);
        chk("sim_read_after_write", 32'(i2c_q[$]), 32'h99);

        // overrun under host contention
        chk("overrun_clear", 32'(i2c_overrun), 32'd0);
        host_req = 1; host_we = 0; host_addr = 8'h40; tick(1);
        i2c_wdata = 8'h31; i2c_wr_req = 1; tick(1);
        host_req = 0; i2c_wr_req = 0; tick(1);
        i2c_wdata = 8'h32; i2c_wr_req = 1; tick(1);
        i2c_wr_req = 0; tick(5);
        chk("overrun_set", 32'(i2c_overrun), 32'd1);
        tick(10);
        chk("overrun_sticky", 32'(i2c_overrun), 32'd1);

        // reset during RD_WAIT of a host read
        hq0 = host_q.size();
        host_req = 1; host_we = 0; host_addr = 8'h10; tick(1);
        tick(1);
        host_req = 0; rst_n = 0; tick(1);
        rst_n = 1; tick(6);
        chk("reset_no_valid", 32'(host_q.size()), 32'(hq0));
        chk("reset_overrun", 32'(i2c_overrun), 32'd0);
        i2c_wdata = 8'h5E; i2c_wr_req = 1; tick(1);
        i2c_wr_req = 0; tick(4);
        chk("reset_ptr_zero", 32'(last_we_addr), 32'h00);
        chk("reset_ptr_data", 32'(last_we_data), 32'h5E);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) i2c_addr_load = ~i2c_addr_load;
            if ($urandom_range(0, 5) == 0) i2c_wr_req = ~i2c_wr_req;
            if ($urandom_range(0, 5) == 0) i2c_rd_req = ~i2c_rd_req;
            if ($urandom_range(0, 5) == 0) i2c_incr = ~i2c_incr;
            i2c_addr_byte = 8'($urandom);
            i2c_wdata = 8'($urandom);
            if (host_req && gnt_last) begin
                if ($urandom_range(0, 3) == 0) begin
                    host_we = 1'($urandom); host_addr = 8'($urandom); host_wdata = 8'($urandom);
                end else begin
                    host_req = 0;
                end
            end else if (!host_req && $urandom_range(0, 4) == 0) begin
                host_req = 1;
                host_we = 1'($urandom); host_addr = 8'($urandom); host_wdata = 8'($urandom);
            end
            rst_n = ($urandom_range(0, 799) != 0);
            tick(1);
        end
        rst_n = 1;
        host_req = 0;
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
